vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter H_VIDEO, default 640, SHALL be the active pixels per line.
REQ-002 Parameter V_VIDEO, default 480, SHALL be the active lines per frame.
REQ-003 Parameter COUNTER_WIDTH, default 10, SHALL be the width of the timing counters.
REQ-004 Parameter ADDR_WIDTH, default 19, SHALL be the framebuffer address width.
REQ-005 Parameter DATA_WIDTH, default 8, SHALL be the pixel/word width.
REQ-006 Parameter FIFO_DEPTH, default 4 (power of two), SHALL be the host write buffer depth.
REQ-007 clk  in  1  single clock; all registers rise on posedge clk.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 h_counter_next, v_counter_next  in  COUNTER_WIDTH each  next-pixel position from the timing generator.
REQ-010 will_display  in  1  next pixel is in the active area.
REQ-011 host_valid, host_ready  in, out  1 each  host write handshake.
REQ-012 host_addr, host_data  in  ADDR_WIDTH, DATA_WIDTH  host write address and data.
REQ-013 mem_en, mem_we  out  1 each  registered memory enable and write enable.
REQ-014 mem_addr, mem_wdata  out  ADDR_WIDTH, DATA_WIDTH  registered memory address and write data.
REQ-015 mem_rdata  in  DATA_WIDTH  synchronous read data, 1-cycle latency after mem_en.
REQ-016 pixel_out, pixel_valid  out  DATA_WIDTH, 1  pixel for display and its qualifier.

Function
REQ-017 Host writes SHALL enter a FIFO_DEPTH FIFO; host_ready = !full; push on host_valid && host_ready.
REQ-018 A per-cycle grant FSM with states IDLE, DISP, WRITE SHALL select the next access: will_display -> DISP; else FIFO non-empty -> WRITE; else IDLE.
REQ-019 Display SHALL have absolute priority; a WRITE SHALL never be issued in a cycle where will_display=1.
REQ-020 DISP SHALL register mem_en=1, mem_we=0, mem_addr=fb_addr.
REQ-021 fb_addr SHALL be 0 when h_counter_next=0 and v_counter_next=0 with will_display=1, else the internal pointer; the pointer SHALL become fb_addr+1 after each DISP.
REQ-022 The pointer SHALL wrap to 0 after H_VIDEO*V_VIDEO-1, independent of the frame-start rule.
REQ-023 WRITE SHALL register mem_en=1, mem_we=1, FIFO head addr/data, and pop the FIFO in the same cycle.
REQ-024 IDLE SHALL register mem_en=0, mem_we=0; mem_addr and mem_wdata SHALL hold their values.
REQ-025 Simultaneous push and pop SHALL leave the FIFO occupancy unchanged; a push to an empty FIFO SHALL become writable the following cycle.
REQ-026 pixel_valid SHALL equal will_display delayed 2 cycles; pixel_out SHALL equal mem_rdata when pixel_valid=1, else 0.
REQ-027 Host writes SHALL be committed to memory in FIFO (arrival) order.

Reset
REQ-028 reset SHALL asynchronously force FSM=IDLE, FIFO empty, pointer=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, pixel_valid=0, pixel_out=0, host_ready=0 while asserted, and host_ready=1 on the first cycle after release.
REQ-029 reset mid-operation SHALL discard buffered writes without issuing them.

Configuration
REQ-030 With VGA_FB_ARB_STALL_CNT_EN defined, output host_stall_count [15:0] SHALL count cycles with host_valid && !host_ready, saturate at 16'hFFFF, and reset to 0.
REQ-031 Without VGA_FB_ARB_STALL_CNT_EN, the port and counter SHALL be absent.

Structure
REQ-032 Package vga_pkg SHALL hold the grant-state enum (IDLE, DISP, WRITE) and the default 640x480 timing constants.
REQ-033 The FIFO SHALL be a sub-module named vga_wr_fifo (parameterised depth/width, full/empty flags).

Verification
REQ-034 Host writes addr 5 data 8'hA5 during blanking -> mem_we=1, mem_addr=5, mem_wdata=8'hA5 two cycles later.
REQ-035 Five back-to-back host writes during active video -> host_ready=0 after the 4th; zero writes issued until will_display=0, then 4 issued in order.
REQ-036 Frame start (h_next=0, v_next=0, will_display=1) -> mem_addr=0, and the next DISP mem_addr=1.
REQ-037 Memory preloaded with rdata=addr[7:0] -> pixel_out sequence 0,1,2... with pixel_valid 2 cycles after will_display.
REQ-038 reset asserted with 3 writes buffered -> mem_en=0 immediately; after release no write is issued and host_ready=1.
REQ-039 With the macro defined, hold host_valid=1 with the FIFO full for 10 cycles -> host_stall_count=10.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared types and constants for the VGA framebuffer arbiter.
//            Holds the grant-state encoding and the default 640x480 active
//            video geometry.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Per-cycle memory grant: who owns the framebuffer port this cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DISP  = 2'd1,
        WRITE = 2'd2
    } grant_state_t;

    // Default active video geometry (640x480).
    localparam int H_VIDEO_DEFAULT = 640;
    localparam int V_VIDEO_DEFAULT = 480;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vga_wr_fifo
// Purpose  : Small synchronous FIFO buffering host framebuffer writes.
//            DEPTH must be a power of two, at least 2. Read data is the
//            current head entry (no read latency); a push into an empty
//            FIFO becomes visible at the head after the next clock edge.
// Ports    : clk, reset (async, active-high)
//            push, wdata        - write side
//            pop, rdata         - read side (head entry)
//            full, empty        - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module vga_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say so.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule : vga_wr_fifo
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter
// Purpose  : Arbitrates a single-port framebuffer between display refresh
//            reads (absolute priority) and buffered host writes.
// Ports    : clk, reset (async, active-high)
//            h_counter_next, v_counter_next, will_display - timing generator
//            host_valid/host_ready/host_addr/host_data    - host write port
//            mem_en/mem_we/mem_addr/mem_wdata/mem_rdata    - memory port
//            pixel_out, pixel_valid                        - display output
//            host_stall_count (only with VGA_FB_ARB_STALL_CNT_EN defined)
// Options  : `define VGA_FB_ARB_STALL_CNT_EN adds a saturating 16-bit count
//            of cycles in which the host is back-pressured.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int H_VIDEO       = H_VIDEO_DEFAULT,
    parameter int V_VIDEO       = V_VIDEO_DEFAULT,
    parameter int COUNTER_WIDTH = 10,
    parameter int ADDR_WIDTH    = 19,
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [COUNTER_WIDTH-1:0] h_counter_next,
    input  logic [COUNTER_WIDTH-1:0] v_counter_next,
    input  logic                     will_display,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic [ADDR_WIDTH-1:0]    host_addr,
    input  logic [DATA_WIDTH-1:0]    host_data,
`ifdef VGA_FB_ARB_STALL_CNT_EN
    output logic [15:0]              host_stall_count,
`endif
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [DATA_WIDTH-1:0]    pixel_out,
    output logic                     pixel_valid
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_VIDEO * V_VIDEO - 1);
    localparam int                    FW        = ADDR_WIDTH + DATA_WIDTH;

    grant_state_t          r_state;
    grant_state_t          w_next_state;
    logic [ADDR_WIDTH-1:0] r_pix_ptr;
    logic [ADDR_WIDTH-1:0] w_fb_addr;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [FW-1:0]         w_fifo_head;
    logic                  r_disp_d1;
    logic                  r_pixel_valid;

    // Ready drops combinationally with reset so the host sees back-pressure
    // for the whole time reset is held.
    assign host_ready = !w_fifo_full && !reset;
    assign w_push     = host_valid && host_ready;
    assign w_pop      = (w_next_state == WRITE);

    vga_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_wr_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .wdata ({host_addr, host_data}),
        .pop   (w_pop),
        .rdata (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Frame start re-synchronises the read pointer to the top-left pixel.
    assign w_fb_addr = (will_display && (h_counter_next == '0) && (v_counter_next == '0))
                       ? '0 : r_pix_ptr;

    always_comb begin
        w_next_state = IDLE;
        if (will_display)       w_next_state = DISP;
        else if (!w_fifo_empty) w_next_state = WRITE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pix_ptr <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            r_state <= w_next_state;
            case (w_next_state)
                DISP: begin
                    mem_addr  <= w_fb_addr;
                    r_pix_ptr <= (w_fb_addr == LAST_ADDR) ? '0 : w_fb_addr + 1'b1;
                end
                WRITE: begin
                    mem_addr  <= w_fifo_head[FW-1:DATA_WIDTH];
                    mem_wdata <= w_fifo_head[DATA_WIDTH-1:0];
                end
                default: ;  // IDLE: address and data hold
            endcase
        end
    end

    // Enables decode straight from the registered grant.
    assign mem_en = (r_state != IDLE);
    assign mem_we = (r_state == WRITE);

    // Two stages: one for the registered request, one for the memory latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp_d1     <= 1'b0;
            r_pixel_valid <= 1'b0;
        end else begin
            r_disp_d1     <= will_display;
            r_pixel_valid <= r_disp_d1;
        end
    end

    assign pixel_valid = r_pixel_valid;
    assign pixel_out   = r_pixel_valid ? mem_rdata : '0;

`ifdef VGA_FB_ARB_STALL_CNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (host_valid && !host_ready && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign host_stall_count = r_stall_count;
`endif

endmodule : vga_fb_arbiter
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_arbiter
// Purpose  : Self-checking bench for vga_fb_arbiter using a reduced 8x2
//            geometry so pointer wrap is reachable. A behavioural memory
//            returns rdata = addr[7:0] one cycle after a read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

    logic        clk;
    logic        reset;
    logic [9:0]  h_counter_next;
    logic [9:0]  v_counter_next;
    logic        will_display;
    logic        host_valid;
    logic        host_ready;
    logic [18:0] host_addr;
    logic [7:0]  host_data;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  pixel_out;
    logic        pixel_valid;
`ifdef VGA_FB_ARB_STALL_CNT_EN
    logic [15:0] host_stall_count;
`endif

    int n_tests;
    int n_fail;
    int n_writes;

    vga_fb_arbiter #(
        .H_VIDEO       (8),
        .V_VIDEO       (2),
        .COUNTER_WIDTH (10),
        .ADDR_WIDTH    (19),
        .DATA_WIDTH    (8),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .h_counter_next   (h_counter_next),
        .v_counter_next   (v_counter_next),
        .will_display     (will_display),
        .host_valid       (host_valid),
        .host_ready       (host_ready),
        .host_addr        (host_addr),
        .host_data        (host_data),
`ifdef VGA_FB_ARB_STALL_CNT_EN
        .host_stall_count (host_stall_count),
`endif
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .pixel_out        (pixel_out),
        .pixel_valid      (pixel_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous read returning the low address byte.
    initial mem_rdata = 8'h00;
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_addr[7:0];
        if (mem_en && mem_we)  n_writes  <= n_writes + 1;
    end

    typedef struct {
        logic        wd;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hv;
        logic [18:0] ha;
        logic [7:0]  hd;
        logic        en;
        logic        we;
        logic [18:0] addr;
        logic [7:0]  wdata;
        logic        rdy;
        logic        pv;
        logic [7:0]  pout;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wd, input logic [9:0] h, input logic [9:0] v,
                         input logic hv, input logic [18:0] ha, input logic [7:0] hd);
        @(negedge clk);
        will_display   = wd;
        h_counter_next = h;
        v_counter_next = v;
        host_valid     = hv;
        host_addr      = ha;
        host_data      = hd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        n_writes = 0;
        reset          = 1'b1;
        will_display   = 1'b0;
        h_counter_next = '0;
        v_counter_next = '0;
        host_valid     = 1'b0;
        host_addr      = '0;
        host_data      = '0;

        //            wd  h      v      hv  ha      hd     en  we  addr    wdata  rdy pv  pout
        tbl[0] = '{1'b1,10'd0,10'd0,1'b0,19'd0, 8'h00,1'b1,1'b0,19'd0, 8'h00,1'b1,1'b0,8'd0};
        tbl[1] = '{1'b1,10'd1,10'd0,1'b0,19'd0, 8'h00,1'b1,1'b0,19'd1, 8'h00,1'b1,1'b1,8'd0};
        tbl[2] = '{1'b1,10'd2,10'd0,1'b1,19'd5, 8'hA5,1'b1,1'b0,19'd2, 8'h00,1'b1,1'b1,8'd1};
        tbl[3] = '{1'b0,10'd0,10'd0,1'b0,19'd0, 8'h00,1'b1,1'b1,19'd5, 8'hA5,1'b1,1'b1,8'd2};
        tbl[4] = '{1'b0,10'd0,10'd0,1'b1,19'd7, 8'h3C,1'b0,1'b0,19'd5, 8'hA5,1'b1,1'b0,8'd0};
        tbl[5] = '{1'b0,10'd0,10'd0,1'b0,19'd0, 8'h00,1'b1,1'b1,19'd7, 8'h3C,1'b1,1'b0,8'd0};
        tbl[6] = '{1'b0,10'd0,10'd0,1'b0,19'd0, 8'h00,1'b0,1'b0,19'd7, 8'h3C,1'b1,1'b0,8'd0};
        tbl[7] = '{1'b1,10'd3,10'd0,1'b0,19'd0, 8'h00,1'b1,1'b0,19'd3, 8'h3C,1'b1,1'b0,8'd0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en",    32'(mem_en),      32'd0);
        chk("rst_mem_we",    32'(mem_we),      32'd0);
        chk("rst_mem_addr",  32'(mem_addr),    32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata),   32'd0);
        chk("rst_pv",        32'(pixel_valid), 32'd0);
        chk("rst_pout",      32'(pixel_out),   32'd0);
        chk("rst_ready",     32'(host_ready),  32'd0);
`ifdef VGA_FB_ARB_STALL_CNT_EN
        chk("rst_stall",     32'(host_stall_count), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_ready", 32'(host_ready), 32'd1);

        // Table-driven: frame start, pixel pipeline, blanking writes, idle hold
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].wd, tbl[i].h, tbl[i].v, tbl[i].hv, tbl[i].ha, tbl[i].hd);
            chk($sformatf("v%0d_en", i),    32'(mem_en),      32'(tbl[i].en));
            chk($sformatf("v%0d_we", i),    32'(mem_we),      32'(tbl[i].we));
            chk($sformatf("v%0d_addr", i),  32'(mem_addr),    32'(tbl[i].addr));
            chk($sformatf("v%0d_wdata", i), 32'(mem_wdata),   32'(tbl[i].wdata));
            chk($sformatf("v%0d_rdy", i),   32'(host_ready),  32'(tbl[i].rdy));
            chk($sformatf("v%0d_pv", i),    32'(pixel_valid), 32'(tbl[i].pv));
            chk($sformatf("v%0d_pout", i),  32'(pixel_out),   32'(tbl[i].pout));
        end

        // Pointer wraps after the last pixel (15 for 8x2) without a frame start
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 10'd1, 10'd1, 1'b0, '0, '0);
            chk($sformatf("wrap%0d_addr", i), 32'(mem_addr), 32'((4 + i) % 16));
        end

        // Frame start forces address 0 even though the pointer is at 2
        drive(1'b1, 10'd0, 10'd0, 1'b0, '0, '0);
        chk("fs_addr", 32'(mem_addr), 32'd0);
        drive(1'b1, 10'd1, 10'd0, 1'b0, '0, '0);
        chk("fs_next_addr", 32'(mem_addr), 32'd1);
        drive(1'b0, 10'd0, 10'd0, 1'b0, '0, '0);

        // Back-to-back host writes during active video fill the FIFO
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 10'd2, 10'd1, 1'b1, 19'(100 + i), 8'(16 + i));
            chk($sformatf("fill%0d_we", i),  32'(mem_we),     32'd0);
            chk($sformatf("fill%0d_rdy", i), 32'(host_ready), (i == 3) ? 32'd0 : 32'd1);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 10'd2, 10'd1, 1'b1, 19'd104, 8'h14);
            chk($sformatf("stall%0d_we", i),  32'(mem_we),     32'd0);
            chk($sformatf("stall%0d_rdy", i), 32'(host_ready), 32'd0);
        end
`ifdef VGA_FB_ARB_STALL_CNT_EN
        chk("stall_count", 32'(host_stall_count), 32'd10);
`endif
        // Blanking: the four buffered writes drain in arrival order
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 10'd0, 10'd0, 1'b0, '0, '0);
            chk($sformatf("drain%0d_we", i),    32'(mem_we),    32'd1);
            chk($sformatf("drain%0d_addr", i),  32'(mem_addr),  32'(100 + i));
            chk($sformatf("drain%0d_wdata", i), 32'(mem_wdata), 32'(16 + i));
        end
        drive(1'b0, 10'd0, 10'd0, 1'b0, '0, '0);
        chk("drained_en",  32'(mem_en),     32'd0);
        chk("drained_rdy", 32'(host_ready), 32'd1);

        // Reset with three writes buffered
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 10'd3, 10'd1, 1'b1, 19'(200 + i), 8'(32 + i));
        end
        chk("pre_rst_en", 32'(mem_en), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_en",    32'(mem_en),      32'd0);
        chk("async_rst_rdy",   32'(host_ready),  32'd0);
        chk("async_rst_pv",    32'(pixel_valid), 32'd0);
        chk("async_rst_addr",  32'(mem_addr),    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset        = 1'b0;
        will_display = 1'b0;
        host_valid   = 1'b0;
        n_writes     = 0;
        #1;
        chk("post_rst_rdy", 32'(host_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 10'd0, 10'd0, 1'b0, '0, '0);
            chk($sformatf("post_rst%0d_en", i), 32'(mem_en), 32'd0);
        end
        chk("post_rst_writes", 32'(n_writes), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_vga_fb_arbiter
`default_nettype wire
